// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: parameter defaults and FSM encoding.
package uart_pkg;

   localparam int unsigned NUM_REQ_DEFAULT  = 4;
   localparam int unsigned GAP_CLKS_DEFAULT = 16;
   localparam int unsigned GAP_CNT_W        = 8;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StIssue    = 2'd1,
      StWaitDone = 2'd2,
      StGap      = 2'd3
   } arb_state_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin selector: picks the first active request after i_Last.
module uart_rr_arb
   import uart_pkg::*;
#(
   parameter  int unsigned NUM_REQ = NUM_REQ_DEFAULT,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_Req,
   input  logic [ID_W-1:0]    i_Last,
   output logic               o_Valid,
   output logic [ID_W-1:0]    o_Index
);

   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= int'(NUM_REQ)) begin
         sum = sum - int'(NUM_REQ);
      end
      return ID_W'(sum);
   endfunction

   always_comb begin
      o_Valid = 1'b0;
      o_Index = '0;
      // Walk far-to-near so the nearest requester after i_Last is the last one written.
      for (int off = int'(NUM_REQ); off >= 1; off--) begin
         if (i_Req[wrap_idx(i_Last, off)]) begin
            o_Valid = 1'b1;
            o_Index = wrap_idx(i_Last, off);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ requesters with round-robin grants and an idle gap
// between frames. All outputs are registered.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int unsigned NUM_REQ  = NUM_REQ_DEFAULT,
   parameter  int unsigned GAP_CLKS = GAP_CLKS_DEFAULT,
   localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic [NUM_REQ-1:0]   i_Req_DV,
   input  logic [8*NUM_REQ-1:0] i_Req_Byte,
   output logic [NUM_REQ-1:0]   o_Req_Ack,
   output logic [NUM_REQ-1:0]   o_Req_Done,
   output logic                 o_Tx_DV,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Active,
   input  logic                 i_Tx_Done,
   output logic                 o_Busy,
   output logic [ID_W-1:0]      o_Grant_Id
);

   localparam logic [GAP_CNT_W-1:0] GAP_MAX    = GAP_CNT_W'(GAP_CLKS);
   localparam logic [ID_W-1:0]      LAST_RESET = ID_W'(NUM_REQ - 1);

   arb_state_t           state_q, state_d;
   logic [ID_W-1:0]      grant_q, grant_d;
   logic [ID_W-1:0]      last_q, last_d;
   logic [7:0]           byte_q, byte_d;
   logic                 dv_q, dv_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 busy_q, busy_d;
   logic [GAP_CNT_W-1:0] gap_q, gap_d;

   logic                 arb_valid;
   logic [ID_W-1:0]      arb_index;
   logic [7:0]           win_byte;

   uart_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arb (
      .i_Req   (i_Req_DV),
      .i_Last  (last_q),
      .o_Valid (arb_valid),
      .o_Index (arb_index)
   );

   always_comb begin
      win_byte = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (arb_index == ID_W'(k)) begin
            win_byte = i_Req_Byte[8*k +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      byte_d  = byte_q;
      gap_d   = gap_q;
      dv_d    = 1'b0;
      ack_d   = '0;
      done_d  = '0;

      case (state_q)
         StIdle: begin
            // uart_tx has no reset, so a frame still in flight must drain before we issue.
            if (arb_valid && !i_Tx_Active && !i_Tx_Done) begin
               state_d = StIssue;
               grant_d = arb_index;
               last_d  = arb_index;
               byte_d  = win_byte;
               dv_d    = 1'b1;
               for (int k = 0; k < int'(NUM_REQ); k++) begin
                  if (arb_index == ID_W'(k)) begin
                     ack_d[k] = 1'b1;
                  end
               end
            end
         end
         StIssue: begin
            state_d = StWaitDone;
         end
         StWaitDone: begin
            if (i_Tx_Done) begin
               state_d = StGap;
               gap_d   = '0;
               for (int k = 0; k < int'(NUM_REQ); k++) begin
                  if (grant_q == ID_W'(k)) begin
                     done_d[k] = 1'b1;
                  end
               end
            end
         end
         StGap: begin
            // Waiting for i_Tx_Done to fall keeps a stretched done pulse from being seen twice.
            if (gap_q != GAP_MAX) begin
               gap_d = gap_q + 1'b1;
            end else if (!i_Tx_Done && !i_Tx_Active) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         last_q  <= LAST_RESET;
         byte_q  <= '0;
         dv_q    <= 1'b0;
         ack_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         byte_q  <= byte_d;
         dv_q    <= dv_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         gap_q   <= gap_d;
      end
   end

   assign o_Req_Ack  = ack_q;
   assign o_Req_Done = done_q;
   assign o_Tx_DV    = dv_q;
   assign o_Tx_Byte  = byte_q;
   assign o_Busy     = busy_q;
   assign o_Grant_Id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural uart_tx line model and a round-robin reference.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int GAP_CLKS = 2;
   localparam int CPB      = 4;

   logic                 i_Clock  = 1'b0;
   logic                 i_Reset  = 1'b1;
   logic [NUM_REQ-1:0]   req_dv   = '0;
   logic [8*NUM_REQ-1:0] req_byte = '0;
   logic [NUM_REQ-1:0]   req_ack;
   logic [NUM_REQ-1:0]   req_done;
   logic                 tx_dv;
   logic [7:0]           tx_byte;
   logic                 busy;
   logic [1:0]           grant_id;
   logic                 tx_active = 1'b0;
   logic                 tx_done;
   logic                 tx_line;

   always #5 i_Clock = ~i_Clock;

   uart_tx_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .GAP_CLKS (GAP_CLKS)
   ) dut (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_Req_DV    (req_dv),
      .i_Req_Byte  (req_byte),
      .o_Req_Ack   (req_ack),
      .o_Req_Done  (req_done),
      .o_Tx_DV     (tx_dv),
      .o_Tx_Byte   (tx_byte),
      .i_Tx_Active (tx_active),
      .i_Tx_Done   (tx_done),
      .o_Busy      (busy),
      .o_Grant_Id  (grant_id)
   );

   // uart_tx stand-in: start bit, 8 data bits LSB first, stop bit, then done for done_len clocks.
   logic [9:0] u_frame     = '1;
   int         u_bit       = 0;
   int         u_clk       = 0;
   int         u_done_left = 0;
   int         done_len    = 1;

   always @(posedge i_Clock) begin
      if (u_done_left > 0) u_done_left <= u_done_left - 1;
      if (!tx_active) begin
         if (tx_dv) begin
            tx_active <= 1'b1;
            u_frame   <= {1'b1, tx_byte, 1'b0};
            u_bit     <= 0;
            u_clk     <= 0;
         end
      end else if (u_clk == CPB - 1) begin
         u_clk <= 0;
         if (u_bit == 9) begin
            tx_active   <= 1'b0;
            u_done_left <= done_len;
         end else begin
            u_bit <= u_bit + 1;
         end
      end else begin
         u_clk <= u_clk + 1;
      end
   end

   assign tx_done = (u_done_left > 0);
   assign tx_line = tx_active ? u_frame[u_bit] : 1'b1;

   // What the DUT saw on the most recent rising edge.
   logic [NUM_REQ-1:0]   req_at_edge    = '0;
   logic [8*NUM_REQ-1:0] byte_at_edge   = '0;
   logic                 active_at_edge = 1'b0;
   logic                 done_at_edge   = 1'b0;

   always @(posedge i_Clock) begin
      req_at_edge    <= req_dv;
      byte_at_edge   <= req_byte;
      active_at_edge <= tx_active;
      done_at_edge   <= tx_done;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic fail_timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout expected event", nm);
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int last);
      for (int d = 1; d <= NUM_REQ; d++) begin
         if (req[(last + d) % NUM_REQ]) return (last + d) % NUM_REQ;
      end
      return NUM_REQ;
   endfunction

   // Monitor / scoreboard state.
   int         cyc           = 0;
   int         ref_last      = NUM_REQ - 1;
   bit         outstanding   = 1'b0;
   int         out_id        = 0;
   bit         have_done     = 1'b0;
   int         last_done_cyc = 0;
   bit         check_spacing = 1'b0;
   bit         capture_line  = 1'b0;
   int         ack_cnt  [NUM_REQ];
   int         done_per [NUM_REQ];
   int         q_id   [$];
   logic [7:0] q_byte [$];
   logic       line_q [$];

   initial begin : monitor
      int exp_id;
      for (int k = 0; k < NUM_REQ; k++) begin
         ack_cnt[k]  = 0;
         done_per[k] = 0;
      end
      forever begin
         @(negedge i_Clock);
         cyc++;
         if (i_Reset) begin
            ref_last    = NUM_REQ - 1;
            outstanding = 1'b0;
            have_done   = 1'b0;
         end else begin
            if (tx_dv) begin
               exp_id = rr_pick(req_at_edge, ref_last);
               chk("grant_id", 32'(grant_id), 32'(exp_id));
               chk("tx_byte", 32'(tx_byte), 32'(byte_at_edge[8*exp_id +: 8]));
               chk("ack_at_issue", 32'(req_ack), 32'd1 << exp_id);
               chk("uart_idle_at_issue", {30'd0, active_at_edge, done_at_edge}, 32'd0);
               chk("busy_at_issue", 32'(busy), 32'd1);
               if (check_spacing && have_done) begin
                  chk("gap_spacing", 32'(cyc - last_done_cyc), 32'(GAP_CLKS + 2));
               end
               q_id.push_back(int'(grant_id));
               q_byte.push_back(tx_byte);
               ref_last    = exp_id;
               outstanding = 1'b1;
               out_id      = exp_id;
            end else if (req_ack != '0) begin
               chk("stray_ack", 32'(req_ack), 32'd0);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
               if (req_ack[k])  ack_cnt[k]++;
               if (req_done[k]) done_per[k]++;
            end
            if (req_done != '0) begin
               chk("done_owner", 32'(req_done), outstanding ? (32'd1 << out_id) : 32'd0);
               outstanding   = 1'b0;
               have_done     = 1'b1;
               last_done_cyc = cyc;
            end
            if (capture_line && tx_active) line_q.push_back(tx_line);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500us");
      $fatal(1);
   end

   task automatic tick();
      @(posedge i_Clock);
      #1;
   endtask

   task automatic wait_ack(input int k, input string nm);
      int t;
      for (t = 0; t < 300; t++) begin
         tick();
         if (req_ack[k]) break;
      end
      if (t == 300) fail_timeout(nm);
   endtask

   task automatic wait_any_ack(input string nm);
      int t;
      for (t = 0; t < 300; t++) begin
         tick();
         if (req_ack != '0) break;
      end
      if (t == 300) fail_timeout(nm);
   endtask

   task automatic wait_idle(input string nm);
      int t;
      for (t = 0; t < 400; t++) begin
         tick();
         if (!busy && !tx_active && !tx_done) break;
      end
      if (t == 400) fail_timeout(nm);
   endtask

   function automatic logic [7:0] row_byte(input int r, input int k);
      return 8'((k + 1) * 16 + r + 1);
   endfunction

   function automatic int total_done();
      int s = 0;
      for (int k = 0; k < NUM_REQ; k++) s += done_per[k];
      return s;
   endfunction

   typedef struct {
      logic [NUM_REQ-1:0] req;
      int                 exp_id;
   } vec_t;

   vec_t vecs [8];

   initial begin : main
      int         base_f;
      int         base_d;
      int         d0;
      int         a2;
      int         t;
      logic [9:0] line_got;
      logic [9:0] exp_line;
      logic [7:0] exp_b [5];
      int         exp_i [5];

      // Pointer sequence starts at last grant 0 (left by the single-request test).
      vecs[0] = '{4'b1111, 1};
      vecs[1] = '{4'b0011, 0};
      vecs[2] = '{4'b1000, 3};
      vecs[3] = '{4'b0110, 1};
      vecs[4] = '{4'b0110, 2};
      vecs[5] = '{4'b0100, 2};
      vecs[6] = '{4'b1001, 3};
      vecs[7] = '{4'b1001, 0};
      exp_line = 10'b1101001010;
      exp_i = '{0, 1, 2, 3, 0};
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

      repeat (3) tick();
      chk("rst_tx_dv", 32'(tx_dv), 32'd0);
      chk("rst_tx_byte", 32'(tx_byte), 32'd0);
      chk("rst_ack", 32'(req_ack), 32'd0);
      chk("rst_done", 32'(req_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      i_Reset = 1'b0;
      repeat (2) tick();

      // Single request, line waveform.
      line_q.delete();
      capture_line = 1'b1;
      base_f = q_id.size();
      req_byte[7:0] = 8'hA5;
      req_dv = 4'b0001;
      wait_ack(0, "f031_ack");
      req_dv = '0;
      wait_idle("f031_idle");
      capture_line = 1'b0;
      chk("f031_frames", 32'(q_id.size() - base_f), 32'd1);
      chk("f031_ack0", 32'(ack_cnt[0]), 32'd1);
      chk("f031_done0", 32'(done_per[0]), 32'd1);
      chk("f031_line_len", 32'(line_q.size()), 32'd40);
      line_got = '0;
      for (int b = 0; b < 10; b++) begin
         if (line_q.size() > 4*b + 2) line_got[b] = line_q[4*b + 2];
      end
      chk("f031_line", 32'(line_got), 32'(exp_line));

      // Arbitration table.
      for (int r = 0; r < 8; r++) begin
         base_f = q_id.size();
         d0 = done_per[vecs[r].exp_id];
         for (int k = 0; k < NUM_REQ; k++) req_byte[8*k +: 8] = row_byte(r, k);
         req_dv = vecs[r].req;
         wait_any_ack($sformatf("row%0d_ack", r));
         req_dv = '0;
         wait_idle($sformatf("row%0d_idle", r));
         chk($sformatf("row%0d_id", r), 32'(grant_id), 32'(vecs[r].exp_id));
         chk($sformatf("row%0d_byte", r), 32'(tx_byte), 32'(row_byte(r, vecs[r].exp_id)));
         chk($sformatf("row%0d_frames", r), 32'(q_id.size() - base_f), 32'd1);
         chk($sformatf("row%0d_done", r), 32'(done_per[vecs[r].exp_id] - d0), 32'd1);
      end

      // All four requesting continuously from a fresh reset.
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
      tick();
      base_f = q_id.size();
      req_byte = {8'h44, 8'h33, 8'h22, 8'h11};
      check_spacing = 1'b1;
      req_dv = 4'b1111;
      for (t = 0; t < 600; t++) begin
         tick();
         if (q_id.size() >= base_f + 5) break;
      end
      if (t == 600) fail_timeout("f032_frames");
      req_dv = '0;
      check_spacing = 1'b0;
      wait_idle("f032_idle");
      for (int i = 0; i < 5; i++) begin
         if (q_id.size() > base_f + i) begin
            chk($sformatf("f032_id%0d", i), 32'(q_id[base_f + i]), 32'(exp_i[i]));
            chk($sformatf("f032_byte%0d", i), 32'(q_byte[base_f + i]), 32'(exp_b[i]));
         end
      end
      chk("f032_count", 32'(q_id.size() - base_f), 32'd5);

      // Requester 2 pulses during another frame and withdraws.
      base_f = q_id.size();
      a2 = ack_cnt[2];
      req_byte[7:0] = 8'h55;
      req_dv = 4'b0001;
      wait_ack(0, "f033_ack0");
      req_dv = '0;
      repeat (8) tick();
      req_byte[23:16] = 8'h77;
      req_dv[2] = 1'b1;
      repeat (6) tick();
      req_dv[2] = 1'b0;
      wait_idle("f033_idle");
      repeat (4) tick();
      chk("f033_frames", 32'(q_id.size() - base_f), 32'd1);
      chk("f033_ack2", 32'(ack_cnt[2] - a2), 32'd0);

      // Two-cycle done pulse.
      done_len = 2;
      base_f = q_id.size();
      base_d = total_done();
      d0 = done_per[1];
      a2 = done_per[3];
      req_byte[31:24] = 8'hC3;
      req_byte[15:8] = 8'h1E;
      req_dv = 4'b1010;
      for (t = 0; t < 400; t++) begin
         tick();
         if (req_ack[1]) req_dv[1] = 1'b0;
         if (req_ack[3]) req_dv[3] = 1'b0;
         if (req_dv == '0) break;
      end
      if (t == 400) fail_timeout("f034_acks");
      req_dv = '0;
      wait_idle("f034_idle");
      chk("f034_frames", 32'(q_id.size() - base_f), 32'd2);
      chk("f034_done_total", 32'(total_done() - base_d), 32'd2);
      chk("f034_done1", 32'(done_per[1] - d0), 32'd1);
      chk("f034_done3", 32'(done_per[3] - a2), 32'd1);
      done_len = 1;

      // Reset during data bits with requester 1 pending.
      base_f = q_id.size();
      d0 = done_per[0];
      req_byte[7:0] = 8'h3C;
      req_byte[15:8] = 8'h96;
      req_dv = 4'b0001;
      wait_ack(0, "f035_ack0");
      req_dv = '0;
      repeat (14) tick();
      req_dv[1] = 1'b1;
      repeat (2) tick();
      i_Reset = 1'b1;
      #1;
      chk("f035_rst_tx_dv", 32'(tx_dv), 32'd0);
      chk("f035_rst_byte", 32'(tx_byte), 32'd0);
      chk("f035_rst_ack", 32'(req_ack), 32'd0);
      chk("f035_rst_done", 32'(req_done), 32'd0);
      chk("f035_rst_busy", 32'(busy), 32'd0);
      chk("f035_rst_grant", 32'(grant_id), 32'd0);
      repeat (2) tick();
      i_Reset = 1'b0;
      wait_ack(1, "f035_ack1");
      req_dv = '0;
      wait_idle("f035_idle");
      chk("f035_frames", 32'(q_id.size() - base_f), 32'd2);
      chk("f035_no_done0", 32'(done_per[0] - d0), 32'd0);
      if (q_id.size() > 0) chk("f035_last_id", 32'(q_id[q_id.size() - 1]), 32'd1);

      // Randomized traffic against the reference in the monitor.
      base_f = q_id.size();
      base_d = total_done();
      for (int c = 0; c < 3000; c++) begin
         tick();
         done_len = $urandom_range(1, 5);
         for (int k = 0; k < NUM_REQ; k++) begin
            if (req_dv[k]) begin
               if (req_ack[k]) req_dv[k] = 1'b0;
               else if ($urandom_range(0, 63) == 0) req_dv[k] = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
               req_byte[8*k +: 8] = 8'($urandom);
               req_dv[k] = 1'b1;
            end
         end
      end
      req_dv = '0;
      wait_idle("rand_idle");
      done_len = 1;
      chk("rand_done_vs_frames", 32'(total_done() - base_d), 32'(q_id.size() - base_f));
      n_cmp++;
      if (q_id.size() - base_f < 20) begin
         n_bad++;
         $display("FAIL rand_throughput: got %0d frames expected at least 20", q_id.size() - base_f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter GAP_CLKS, default 16: minimum idle clocks between the end of one frame and the next o_Tx_DV; legal range 0..255.
REQ-003 i_Clock  input  1  single clock; all logic is rising-edge.
REQ-004 i_Reset  input  1  asynchronous, active-high reset.
REQ-005 i_Req_DV  input  NUM_REQ  per-requester byte-valid; bit k is held high until o_Req_Ack[k].
REQ-006 i_Req_Byte  input  8*NUM_REQ  per-requester byte; requester k occupies bits [8k+7:8k] and holds them stable while i_Req_DV[k] is high.
REQ-007 o_Req_Ack  output  NUM_REQ  one-cycle pulse: the byte of requester k has been accepted.
REQ-008 o_Req_Done  output  NUM_REQ  one-cycle pulse: the frame of requester k has completed on the line.
REQ-009 o_Tx_DV  output  1  drives i_Tx_DV of uart_tx.
REQ-010 o_Tx_Byte  output  8  drives i_Tx_Byte of uart_tx.
REQ-011 i_Tx_Active  input  1  from o_Tx_Active of uart_tx.
REQ-012 i_Tx_Done  input  1  from o_Tx_Done of uart_tx.
REQ-013 o_Busy  output  1  high in every state except IDLE.
REQ-014 o_Grant_Id  output  clog2(NUM_REQ)  index of the current or most recent grant.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_DONE, GAP. All outputs are registered.
REQ-016 IDLE->ISSUE on the edge where |i_Req_DV, !i_Tx_Active and !i_Tx_Done all hold; on that edge the block latches the winner into o_Grant_Id and its byte into o_Tx_Byte.
REQ-017 Round-robin arbitration: the search starts at (last grant + 1) mod NUM_REQ. After reset the last-grant pointer is NUM_REQ-1, so requester 0 has first priority.
REQ-018 In ISSUE, o_Tx_DV and o_Req_Ack[grant] are high for exactly one cycle; the next state is WAIT_DONE unconditionally.
REQ-019 Latency: a request seen in IDLE at edge E puts o_Tx_DV high from E to E+1.
REQ-020 o_Tx_Byte holds its value from ISSUE until the next grant.
REQ-021 WAIT_DONE->GAP on the first edge with i_Tx_Done=1. On that edge the block pulses o_Req_Done[grant] once and clears the gap counter.
REQ-022 GAP increments the counter, which saturates at GAP_CLKS. GAP->IDLE only when counter==GAP_CLKS and i_Tx_Done=0 and i_Tx_Active=0, so the multi-cycle o_Tx_Done of uart_tx yields exactly one o_Req_Done.
REQ-023 Requests arriving outside IDLE wait. Deasserting i_Req_DV[k] before its ack withdraws the request with no other effect.
REQ-024 Simultaneous requests: exactly one o_Req_Ack per frame; a lone requester is re-granted back-to-back, limited only by the gap.
REQ-025 Out-of-range o_Grant_Id (NUM_REQ not a power of 2) never occurs. An illegal state encoding returns the FSM to IDLE.

Reset
REQ-026 When i_Reset is high: state=IDLE, o_Tx_DV=0, o_Tx_Byte=0, o_Req_Ack=0, o_Req_Done=0, o_Busy=0, o_Grant_Id=0, last-grant pointer=NUM_REQ-1, gap counter=0.
REQ-027 Reset mid-frame drops the pending o_Req_Done. uart_tx has no reset, so after reset release no o_Tx_DV is issued until i_Tx_Active=0 and i_Tx_Done=0 (per REQ-016).

Structure
REQ-028 State encodings and the NUM_REQ/GAP_CLKS defaults belong in the shared package uart_pkg.
REQ-029 The round-robin selector is a combinational sub-module named uart_rr_arb: inputs are the request vector and the last-grant pointer; outputs are the valid flag and the index.
REQ-030 uart_tx is instantiated by the parent, not inside this block.

Verification (bench: uart_tx with CLKS_PER_BIT=4, NUM_REQ=4, GAP_CLKS=2)
REQ-031 Single request: i_Req_DV=4'b0001, byte 8'hA5 -> one o_Req_Ack[0]; line shows 0,1,0,1,0,0,1,0,1,1 at 4 clk/bit; one o_Req_Done[0].
REQ-032 All four requesting continuously with bytes 11/22/33/44 -> frames in order 0,1,2,3,0, one ack each; idle gap between frames is at least 2 clocks.
REQ-033 Requester 2 pulses i_Req_DV during another requester's frame, then drops it before IDLE -> never acked, no o_Tx_DV on its behalf.
REQ-034 i_Tx_Done high for 2 cycles at frame end -> exactly one o_Req_Done pulse; no new o_Tx_DV while i_Tx_Done=1.
REQ-035 i_Reset asserted mid data bits with requester 1 pending -> outputs reach reset values immediately; o_Tx_DV for requester 1 is issued only after uart_tx returns idle (i_Tx_Active=0 and i_Tx_Done=0); no o_Req_Done for the aborted frame.
